// File: rtl/router_pkg.sv
// Shared router definitions: scheduler state encoding, default port count,
// and the one-hot helper used to build grant vectors.
package router_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

    // One-hot vector with bit idx set; callers keep the low bits they need.
    function automatic logic [31:0] onehot(input logic [4:0] idx);
        onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: finds the first asserted req bit scanning
// upward from ptr and wrapping from N-1 back to 0.
module rr_pick
    import router_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic            found_s;
    logic [IDXW-1:0] idx_s;
    logic [IDXW:0]   sum_s;
    logic [IDXW-1:0] cand_s;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        found_s = 1'b0;
        idx_s   = {IDXW{1'b0}};
        sum_s   = {(IDXW+1){1'b0}};
        cand_s  = {IDXW{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            sum_s = {1'b0, ptr} + (IDXW+1)'(k);
            if (sum_s >= (IDXW+1)'(N)) begin
                sum_s = sum_s - (IDXW+1)'(N);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDXW-1:0];
            if (req[cand_s]) begin
                found_s = 1'b1;
                idx_s   = cand_s;
            end else begin
                found_s = found_s;
                idx_s   = idx_s;
            end
        end
    end

    assign found = found_s;
    assign idx   = idx_s;

endmodule

// File: rtl/rr_output_scheduler.sv
// Round-robin, packet-granular scheduler for one router output port. A winner
// keeps the port from head flit until its tail flit is accepted downstream.
module rr_output_scheduler
    import router_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int IDXW = $clog2(N)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    tail,
    input  logic            out_ready,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            busy,
    output logic [N-1:0]    in_ready,
    output logic            xfer
);

    sched_state_t    state_r, state_s;
    logic [IDXW-1:0] ptr_r, ptr_s;
    logic [N-1:0]    grant_r, grant_s;
    logic [IDXW-1:0] grant_idx_r, grant_idx_s;
    logic            busy_r, busy_s;

    logic            found_s;
    logic [IDXW-1:0] pick_idx_s;
    logic [31:0]     pick_oh_s;
    logic            xfer_s;

    rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .found (found_s),
        .idx   (pick_idx_s)
    );

    assign pick_oh_s = onehot(5'(pick_idx_s));

    // A flit moves only while a packet owns the port and both ends are ready.
    assign xfer_s = busy_r & req[grant_idx_r] & out_ready;

    // Next-state logic: arbitrate in IDLE, hold the lock in BUSY until tail.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        grant_s     = grant_r;
        grant_idx_s = grant_idx_r;
        busy_s      = busy_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s     = BUSY;
                    grant_s     = pick_oh_s[N-1:0];
                    grant_idx_s = pick_idx_s;
                    busy_s      = 1'b1;
                end else begin
                    state_s     = IDLE;
                    grant_s     = {N{1'b0}};
                    grant_idx_s = {IDXW{1'b0}};
                    busy_s      = 1'b0;
                end
            end
            BUSY: begin
                if (xfer_s && tail[grant_idx_r]) begin
                    state_s     = IDLE;
                    grant_s     = {N{1'b0}};
                    grant_idx_s = {IDXW{1'b0}};
                    busy_s      = 1'b0;
                    if (grant_idx_r == IDXW'(N - 1)) begin
                        ptr_s = {IDXW{1'b0}};
                    end else begin
                        ptr_s = grant_idx_r + IDXW'(1);
                    end
                end else begin
                    state_s = BUSY;
                end
            end
            default: begin
                state_s     = IDLE;
                ptr_s       = {IDXW{1'b0}};
                grant_s     = {N{1'b0}};
                grant_idx_s = {IDXW{1'b0}};
                busy_s      = 1'b0;
            end
        endcase
    end

    // State and grant registers; RESET wins over any transition.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= IDLE;
            ptr_r       <= {IDXW{1'b0}};
            grant_r     <= {N{1'b0}};
            grant_idx_r <= {IDXW{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            grant_r     <= grant_s;
            grant_idx_r <= grant_idx_s;
            busy_r      <= busy_s;
        end
    end

    assign grant     = grant_r;
    assign grant_idx = grant_idx_r;
    assign busy      = busy_r;
    assign in_ready  = grant_r & {N{out_ready}};
    assign xfer      = xfer_s;

endmodule

// File: tb/tb_rr_output_scheduler.sv
// Self-checking bench for rr_output_scheduler: directed scenarios followed by
// random traffic, all checked against a packet-level reference model.
module tb_rr_output_scheduler;

    localparam int N    = 4;
    localparam int IDXW = 2;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    tail = '0;
    logic            out_ready = 1'b0;
    logic [N-1:0]    grant;
    logic [IDXW-1:0] grant_idx;
    logic            busy;
    logic [N-1:0]    in_ready;
    logic            xfer;

    int total = 0;
    int bad   = 0;

    // Reference model: owner = -1 when the port is free.
    int m_owner = -1;
    int m_ptr   = 0;

    logic [N-1:0] seen_grants[$];

    rr_output_scheduler #(.N(N), .IDXW(IDXW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req       (req),
        .tail      (tail),
        .out_ready (out_ready),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .in_ready  (in_ready),
        .xfer      (xfer)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, compare all outputs with the model, then
    // advance the model by the edge that follows.
    task automatic step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] t,
                        input logic ordy);
        logic [N-1:0] e_grant;
        int           e_idx;
        logic         e_busy;
        logic         e_xfer;
        @(negedge CLK);
        RESET = rst; req = r; tail = t; out_ready = ordy;
        #1;
        e_grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        e_idx   = (m_owner < 0) ? 0 : m_owner;
        e_busy  = (m_owner >= 0);
        e_xfer  = (m_owner >= 0) && r[m_owner] && ordy;
        chk("grant",     32'(grant),     32'(e_grant));
        chk("grant_idx", 32'(grant_idx), 32'(e_idx));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("in_ready",  32'(in_ready),  32'(ordy ? e_grant : '0));
        chk("xfer",      32'(xfer),      32'(e_xfer));
        if (grant != '0) seen_grants.push_back(grant);
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            end
        end else if (e_xfer && t[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
    endtask

    initial begin
        logic [N-1:0] exp_seq[5];
        logic [N-1:0] r_rand;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset for two cycles, then idle with no requests.
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 4'b0000, 1'b1);

        // Fairness: all inputs request single-flit packets continuously.
        seen_grants.delete();
        for (int i = 0; i < 10; i++) step(1'b0, 4'b1111, 4'b1111, 1'b1);
        chk("rr_count", 32'(seen_grants.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < seen_grants.size()) chk("rr_seq", 32'(seen_grants[i]), 32'(exp_seq[i]));
        end

        // Packet lock: input 1 sends three flits while input 2 waits.
        step(1'b0, 4'b0110, 4'b0000, 1'b1);
        step(1'b0, 4'b0110, 4'b0000, 1'b1);
        step(1'b0, 4'b0110, 4'b0000, 1'b1);
        chk("lock_grant", 32'(grant), 32'(4'b0010));
        step(1'b0, 4'b0110, 4'b0010, 1'b1);
        step(1'b0, 4'b0100, 4'b0000, 1'b1);
        step(1'b0, 4'b0100, 4'b0100, 1'b1);
        chk("lock_next", 32'(grant), 32'(4'b0100));
        step(1'b0, 4'b0000, 4'b0000, 1'b1);

        // Wrap: ptr is 3, inputs 0 and 1 request single-flit packets.
        step(1'b0, 4'b0011, 4'b0011, 1'b1);
        step(1'b0, 4'b0011, 4'b0011, 1'b1);
        chk("wrap_grant0", 32'(grant), 32'(4'b0001));
        step(1'b0, 4'b0011, 4'b0011, 1'b1);
        step(1'b0, 4'b0011, 4'b0011, 1'b1);
        chk("wrap_grant1", 32'(grant), 32'(4'b0010));
        step(1'b0, 4'b0000, 4'b0000, 1'b1);

        // Stall then input bubble mid-packet on input 2.
        step(1'b0, 4'b0100, 4'b0000, 1'b1);
        step(1'b0, 4'b0100, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 4'b1111, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 4'b1011, 4'b1111, 1'b1);
        chk("bubble_hold", 32'(grant), 32'(4'b0100));
        step(1'b0, 4'b0100, 4'b0100, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 1'b1);

        // Reset mid-packet after one flit of input 3.
        step(1'b0, 4'b1000, 4'b0000, 1'b1);
        step(1'b0, 4'b1000, 4'b0000, 1'b1);
        step(1'b1, 4'b1000, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 4'b0000, 1'b1);
        step(1'b0, 4'b0100, 4'b0000, 1'b1);
        step(1'b0, 4'b0100, 4'b0100, 1'b1);
        chk("post_reset", 32'(grant), 32'(4'b0100));
        step(1'b0, 4'b0000, 4'b0000, 1'b1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            r_rand = 4'($urandom);
            step(($urandom_range(0, 49) == 0), r_rand, 4'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
